bht_update_ctrl: RTL and testbench

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl_if.sv | 57 +++++
 rtl/bht_update_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bht_update_ctrl_if.sv
// Signal bundle joining the BHT update controller to fetch, the branch-resolve stage
// and the single-ported BHT array.
interface bht_update_ctrl_if;
    logic       lookup_valid;
    logic [4:0] lookup_addr;
    logic       lookup_ready;
    logic       upd_valid;
    logic [4:0] upd_addr;
    logic       upd_taken;
    logic       upd_ready;
    logic       bht_en;
    logic       bht_we;
    logic [4:0] bht_addr;
    logic [1:0] bht_wdata;
    logic [1:0] bht_rdata;
    logic       pred_valid;
    logic       prediction;
    logic       init_done;

    // Environment side: fetch, resolve stage and the BHT array read data
    modport master (
        output lookup_valid,
        output lookup_addr,
        input  lookup_ready,
        output upd_valid,
        output upd_addr,
        output upd_taken,
        input  upd_ready,
        input  bht_en,
        input  bht_we,
        input  bht_addr,
        input  bht_wdata,
        output bht_rdata,
        input  pred_valid,
        input  prediction,
        input  init_done
    );

    // Controller side
    modport slave (
        input  lookup_valid,
        input  lookup_addr,
        output lookup_ready,
        input  upd_valid,
        input  upd_addr,
        input  upd_taken,
        output upd_ready,
        output bht_en,
        output bht_we,
        output bht_addr,
        output bht_wdata,
        input  bht_rdata,
        output pred_valid,
        output prediction,
        output init_done
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// Owns the single BHT port: initialisation sweep, fetch lookups and read-modify-write
// of 2-bit counters for resolved branches queued in a small in-order FIFO.
module bht_update_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             arst,
    bht_update_ctrl_if.slave bus
);
    localparam int unsigned AW = 5;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_UPD_RD,
        S_UPD_WR
    } state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          taken;
    } upd_t;

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    upd_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    rd_cap_q;
    logic          init_done_q;
    logic          pred_valid_q;
    logic          prediction_q;
    logic          full, empty, push, pop, capture, lookup_hit;
    upd_t          head;

    // Saturating 2-bit counter transition
    function automatic logic [1:0] next_ctr(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b10:   nxt = taken ? 2'b11 : 2'b00;
            default: nxt = taken ? 2'b11 : 2'b10;
        endcase
        return nxt;
    endfunction

    assign full           = (count_q == CW'(FIFO_DEPTH));
    assign empty          = (count_q == '0);
    assign head           = fifo_mem[rd_ptr_q];
    assign bus.upd_ready  = init_done_q & ~full;
    assign push           = bus.upd_valid & bus.upd_ready;
    assign bus.init_done  = init_done_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.prediction = prediction_q;

    // Next-state and BHT port sequencing
    always_comb begin : fsm_comb
        state_d          = state_q;
        sweep_d          = sweep_q;
        lookup_hit       = 1'b0;
        pop              = 1'b0;
        capture          = 1'b0;
        bus.lookup_ready = 1'b0;
        bus.bht_en       = 1'b0;
        bus.bht_we       = 1'b0;
        bus.bht_addr     = '0;
        bus.bht_wdata    = '0;
        case (state_q)
            S_INIT: begin
                bus.bht_en    = 1'b1;
                bus.bht_we    = 1'b1;
                bus.bht_addr  = sweep_q;
                bus.bht_wdata = INIT_STATE;
                sweep_d       = sweep_q + AW'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // A full FIFO blocks lookups so queued updates cannot starve
                if (bus.lookup_valid && !full) begin
                    lookup_hit       = 1'b1;
                    bus.lookup_ready = 1'b1;
                    bus.bht_en       = 1'b1;
                    bus.bht_addr     = bus.lookup_addr;
                end else if (!empty) begin
                    state_d = S_UPD_RD;
                end
            end
            S_UPD_RD: begin
                bus.bht_en   = 1'b1;
                bus.bht_addr = head.addr;
                capture      = 1'b1;
                state_d      = S_UPD_WR;
            end
            S_UPD_WR: begin
                bus.bht_en    = 1'b1;
                bus.bht_we    = 1'b1;
                bus.bht_addr  = head.addr;
                bus.bht_wdata = next_ctr(rd_cap_q, head.taken);
                pop           = 1'b1;
                state_d       = S_IDLE;
            end
        endcase
        if (arst) begin
            bus.bht_en = 1'b0;
            bus.bht_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin : state_reg
        if (arst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or posedge arst) begin : fifo_ctrl
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin : fifo_store
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{addr: bus.upd_addr, taken: bus.upd_taken};
        end
    end

    always_ff @(posedge clk or posedge arst) begin : data_regs
        if (arst) begin
            rd_cap_q     <= '0;
            init_done_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
        end else begin
            if (capture) begin
                rd_cap_q <= bus.bht_rdata;
            end
            init_done_q  <= (state_d != S_INIT);
            pred_valid_q <= lookup_hit;
            if (lookup_hit) begin
                prediction_q <= bus.bht_rdata[1];
            end
        end
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed and randomized checks of bht_update_ctrl against a queue-based reference model,
// with a bench-side BHT array answering the controller's port.
module tb_bht_update_ctrl;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_VAL = 2'b01;

    typedef struct packed {
        logic [4:0] addr;
        logic       taken;
    } upd_t;

    logic clk = 1'b0;
    logic arst;
    int   tests = 0;
    int   fails = 0;

    bht_update_ctrl_if bus ();

    logic [1:0] bht_mem [32];
    logic [1:0] wlog [$];
    logic       log_on;
    int         writes_in_reset = 0;

    // Reference model state
    logic [1:0] ref_bht [32];
    upd_t       pend [$];
    int         init_left;
    int         phase;
    logic       exp_pv;
    logic       exp_pred;

    bht_update_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .INIT_STATE(INIT_VAL)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.bht_rdata = bht_mem[bus.bht_addr];

    always @(posedge clk) begin
        if (bus.bht_en && bus.bht_we) begin
            bht_mem[bus.bht_addr] <= bus.bht_wdata;
            if (log_on && bus.bht_addr == 5'd3) wlog.push_back(bus.bht_wdata);
            if (arst) writes_in_reset <= writes_in_reset + 1;
        end
    end

    function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd0) ? 2'd1 : 2'd3;
        return (c == 2'd3) ? 2'd2 : 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        init_left = 32;
        phase     = 0;
        pend.delete();
        exp_pv    = 1'b0;
        exp_pred  = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model
    task automatic step(input logic lv, input logic [4:0] la, input logic uv,
                        input logic [4:0] ua, input logic ut);
        logic       e_en, e_we, e_lr, e_ur, serve, start, push;
        logic [4:0] e_addr;
        logic [1:0] e_wd;
        bus.lookup_valid = lv;
        bus.lookup_addr  = la;
        bus.upd_valid    = uv;
        bus.upd_addr     = ua;
        bus.upd_taken    = ut;
        #1;
        e_en = 1'b0; e_we = 1'b0; e_lr = 1'b0; serve = 1'b0; start = 1'b0;
        e_addr = 5'd0; e_wd = 2'd0;
        if (init_left > 0) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = 5'(32 - init_left); e_wd = INIT_VAL;
        end else if (phase == 1) begin
            e_en = 1'b1; e_addr = pend[0].addr;
        end else if (phase == 2) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = pend[0].addr;
            e_wd = ref_next(ref_bht[pend[0].addr], pend[0].taken);
        end else if (lv && pend.size() < DEPTH) begin
            serve = 1'b1; e_lr = 1'b1; e_en = 1'b1; e_addr = la;
        end else if (pend.size() > 0) begin
            start = 1'b1;
        end
        e_ur = (init_left == 0) && (pend.size() < DEPTH);
        push = uv && e_ur;
        chk("lookup_ready", 32'(bus.lookup_ready), 32'(e_lr));
        chk("upd_ready", 32'(bus.upd_ready), 32'(e_ur));
        chk("bht_en", 32'(bus.bht_en), 32'(e_en));
        chk("bht_we", 32'(bus.bht_we), 32'(e_we));
        if (e_en) chk("bht_addr", 32'(bus.bht_addr), 32'(e_addr));
        if (e_we) chk("bht_wdata", 32'(bus.bht_wdata), 32'(e_wd));
        chk("pred_valid", 32'(bus.pred_valid), 32'(exp_pv));
        chk("prediction", 32'(bus.prediction), 32'(exp_pred));
        chk("init_done", 32'(bus.init_done), 32'(init_left == 0));
        @(posedge clk);
        if (init_left > 0) begin
            ref_bht[32 - init_left] = INIT_VAL;
            init_left--;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            ref_bht[pend[0].addr] = e_wd;
            void'(pend.pop_front());
            phase = 0;
        end else if (start) begin
            phase = 1;
        end
        exp_pv = serve;
        if (serve) exp_pred = ref_bht[la][1];
        if (push) pend.push_back('{addr: ua, taken: ut});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        arst             = 1'b1;
        log_on           = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr  = 5'd0;
        bus.upd_valid    = 1'b0;
        bus.upd_addr     = 5'd0;
        bus.upd_taken    = 1'b0;
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst_bht_en", 32'(bus.bht_en), 32'd0);
        chk("rst_bht_we", 32'(bus.bht_we), 32'd0);
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        chk("rst_prediction", 32'(bus.prediction), 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_lookup_ready", 32'(bus.lookup_ready), 32'd0);
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // Sweep with requests offered; none may be accepted
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 1'b1, 5'(i), 1'b1);
        idle(1);
        for (int i = 0; i < 32; i++) chk("sweep_mem", 32'(bht_mem[i]), 32'(INIT_VAL));

        // Three taken then two not-taken to address 3
        log_on = 1'b1;
        step(1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        step(1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        idle(16);
        log_on = 1'b0;
        chk("addr3_writes", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) begin
            chk("addr3_w0", 32'(wlog[0]), 32'h3);
            chk("addr3_w1", 32'(wlog[1]), 32'h3);
            chk("addr3_w2", 32'(wlog[2]), 32'h3);
            chk("addr3_w3", 32'(wlog[3]), 32'h2);
            chk("addr3_w4", 32'(wlog[4]), 32'h0);
        end

        // Drive address 7 to 2'b10 and look it up
        step(1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        idle(8);
        chk("addr7_mem", 32'(bht_mem[7]), 32'h2);
        step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        chk("addr7_pred_valid", 32'(bus.pred_valid), 32'd1);
        chk("addr7_prediction", 32'(bus.prediction), 32'd1);

        // Fill the FIFO with lookups held, then push while full
        for (int i = 0; i < 4; i++) step(1'b1, 5'(16 + i), 1'b1, 5'(20 + i), 1'(i));
        step(1'b1, 5'd16, 1'b1, 5'd24, 1'b1);
        step(1'b1, 5'd17, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd18, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'(i), 1'b0, 5'd0, 1'b0);

        // Push and pop together at occupancy 3, then refill to full
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 1'b1, 5'd25, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd26, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd27, 1'b1);
        idle(20);

        // Reset during a read-modify-write with two entries queued
        step(1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
        step(1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
        #1;
        chk("abort_rd_en", 32'(bus.bht_en), 32'd1);
        chk("abort_rd_we", 32'(bus.bht_we), 32'd0);
        chk("abort_rd_addr", 32'(bus.bht_addr), 32'd9);
        arst = 1'b1;
        #1;
        chk("abort_bht_en", 32'(bus.bht_en), 32'd0);
        chk("abort_bht_we", 32'(bus.bht_we), 32'd0);
        chk("abort_init_done", 32'(bus.init_done), 32'd0);
        chk("abort_upd_ready", 32'(bus.upd_ready), 32'd0);
        chk("abort_pred_valid", 32'(bus.pred_valid), 32'd0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        model_reset();
        chk("abort_writes_in_reset", 32'(writes_in_reset), 32'd0);
        chk("abort_addr9_untouched", 32'(bht_mem[9]), 32'(INIT_VAL));
        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(10);

        // Randomized traffic with address collisions
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        idle(20);
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(bht_mem[i]), 32'(ref_bht[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
